// File: rtl/display_sequencer_if.sv
// Handshake and display bus between game logic (master) and the display sequencer (slave).
interface display_sequencer_if;
    logic        vs;
    logic        start;
    logic        game_over;
    logic        upd_req;
    logic [63:0] matrix_in;
    logic [63:0] matrix_out;
    logic [3:0]  mode;
    logic        upd_ack;
    logic [5:0]  frame_cnt;

    modport master (
        output vs, start, game_over, upd_req, matrix_in,
        input  matrix_out, mode, upd_ack, frame_cnt
    );

    modport slave (
        input  vs, start, game_over, upd_req, matrix_in,
        output matrix_out, mode, upd_ack, frame_cnt
    );
endinterface

// File: rtl/display_sequencer.sv
// Frame-synchronous screen sequencer: BEGIN/PLAY/OVER screens, blink on game over,
// and a once-per-frame board update handshake that never stalls the game logic.
module display_sequencer #(
    parameter int BLINK_HALF = 32
) (
    input logic               clk,
    input logic               rst,
    display_sequencer_if.slave bus
);
    localparam int BLINK_BIT = $clog2(BLINK_HALF);

    typedef enum logic [1:0] {
        ST_BEGIN = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        vs_d;
    logic        frame_tick;
    logic        start_pend;
    // One bit wider than frame_cnt so the blink bit exists even for BLINK_HALF = 64.
    logic [6:0]  cnt, cnt_next;
    logic [3:0]  mode_q, mode_next;
    logic [63:0] matrix_q;
    logic        ack_q;

    assign frame_tick     = vs_d & ~bus.vs;
    assign bus.mode       = mode_q;
    assign bus.matrix_out = matrix_q;
    assign bus.upd_ack    = ack_q;
    assign bus.frame_cnt  = cnt[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BEGIN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (frame_tick) begin
            cnt_next = cnt + 7'd1;
            case (state)
                ST_BEGIN: if (start_pend) state_next = ST_PLAY;
                ST_PLAY: begin
                    if (bus.game_over) begin
                        state_next = ST_OVER;
                        cnt_next   = '0;
                    end
                end
                ST_OVER:  if (start_pend) state_next = ST_BEGIN;
                default:  state_next = ST_BEGIN;
            endcase
        end

        // Mode is computed from next-state values so the registered output is current.
        case (state_next)
            ST_PLAY: mode_next = 4'd1;
            ST_OVER: mode_next = cnt_next[BLINK_BIT] ? 4'd1 : 4'd2;
            default: mode_next = 4'd0;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d       <= 1'b1;
            start_pend <= 1'b0;
            cnt        <= '0;
            mode_q     <= 4'd0;
            matrix_q   <= '0;
            ack_q      <= 1'b0;
        end else begin
            vs_d   <= bus.vs;
            cnt    <= cnt_next;
            mode_q <= mode_next;
            ack_q  <= frame_tick & bus.upd_req;

            if (state == ST_PLAY || (frame_tick && start_pend)) begin
                start_pend <= 1'b0;
            end else if (bus.start) begin
                start_pend <= 1'b1;
            end

            // Updates outside PLAY are acknowledged but discarded.
            if (frame_tick) begin
                if (state == ST_PLAY && bus.upd_req) begin
                    matrix_q <= bus.matrix_in;
                end else if (state == ST_OVER && start_pend) begin
                    matrix_q <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer: directed scenarios plus randomized frames
// compared cycle by cycle against a screen-level reference model.
module tb_display_sequencer;
    localparam int BH = 32;

    logic clk = 1'b0;
    logic rst;

    display_sequencer_if bus ();

    display_sequencer #(.BLINK_HALF(BH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_count = 0;

    // Reference model: screen number, pending start, frame counts, shown board, ack.
    int          m_screen;
    bit          m_pend;
    int          m_frames;
    int          m_over_frames;
    logic [63:0] m_board;
    bit          m_ack;
    bit          m_vs_prev;

    function automatic void model_reset();
        m_screen      = 0;
        m_pend        = 1'b0;
        m_frames      = 0;
        m_over_frames = 0;
        m_board       = '0;
        m_ack         = 1'b0;
        m_vs_prev     = 1'b1;
    endfunction

    function automatic void model_step();
        bit tick;
        int old_screen;
        if (rst) begin
            model_reset();
            return;
        end
        tick       = m_vs_prev && !bus.vs;
        old_screen = m_screen;
        m_ack      = tick && bus.upd_req;
        if (tick) begin
            m_frames      = (m_frames + 1) % 64;
            m_over_frames = m_over_frames + 1;
            if (old_screen == 0 && m_pend) begin
                m_screen = 1;
            end else if (old_screen == 1) begin
                if (bus.upd_req) m_board = bus.matrix_in;
                if (bus.game_over) begin
                    m_screen      = 2;
                    m_frames      = 0;
                    m_over_frames = 0;
                end
            end else if (old_screen == 2 && m_pend) begin
                m_screen = 0;
                m_board  = '0;
            end
        end
        if (old_screen == 1 || (tick && m_pend)) m_pend = 1'b0;
        else if (bus.start) m_pend = 1'b1;
        m_vs_prev = bus.vs;
    endfunction

    function automatic logic [3:0] model_mode();
        if (m_screen == 0) return 4'd0;
        if (m_screen == 1) return 4'd1;
        return ((m_over_frames / BH) % 2 == 1) ? 4'd1 : 4'd2;
    endfunction

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        logic [3:0] exp_mode;
        logic [5:0] exp_cnt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_mode = model_mode();
        exp_cnt  = 6'(m_frames);
        if (bus.upd_ack === 1'b1) ack_count++;
        checks++;
        if (bus.mode !== exp_mode) begin
            errors++;
            $display("FAIL model_mode: got %0d expected %0d at %0t", bus.mode, exp_mode, $time);
        end
        checks++;
        if (bus.matrix_out !== m_board) begin
            errors++;
            $display("FAIL model_matrix: got %h expected %h at %0t", bus.matrix_out, m_board, $time);
        end
        checks++;
        if (bus.upd_ack !== m_ack) begin
            errors++;
            $display("FAIL model_ack: got %b expected %b at %0t", bus.upd_ack, m_ack, $time);
        end
        checks++;
        if (bus.frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL model_frame_cnt: got %0d expected %0d at %0t", bus.frame_cnt, exp_cnt, $time);
        end
    endtask

    task automatic tick_frame(input int len);
        bus.vs = 1'b0;
        cycle();
        bus.vs = 1'b1;
        repeat (len - 1) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        ack_count = 0;
        for (int i = 0; i < 1000; i++) begin
            bus.upd_req   = 1'($urandom_range(0, 1));
            bus.game_over = 1'($urandom_range(0, 1));
            bus.matrix_in = {$urandom, $urandom};
            cycle();
        end
        bus.upd_req   = 1'b0;
        bus.game_over = 1'b0;
        checks++;
        if (bus.mode !== 4'd0 || bus.matrix_out !== 64'd0 || bus.frame_cnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_idle: mode=%0d matrix=%h cnt=%0d expected 0/0/0",
                     bus.mode, bus.matrix_out, bus.frame_cnt);
        end
        checks++;
        if (ack_count !== 0) begin
            errors++;
            $display("FAIL reset_no_ack: got %0d acks expected 0", ack_count);
        end
    endtask

    task automatic test_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        repeat (3) cycle();
        bus.vs = 1'b0;
        cycle();
        checks++;
        if (bus.mode !== 4'd1 || bus.frame_cnt !== 6'd1) begin
            errors++;
            $display("FAIL start_to_play: mode=%0d cnt=%0d expected 1/1", bus.mode, bus.frame_cnt);
        end
        bus.vs = 1'b1;
        cycle();
    endtask

    task automatic test_update();
        ack_count     = 0;
        bus.upd_req   = 1'b1;
        bus.matrix_in = 64'h0000_0000_0000_1021;
        repeat (5) cycle();
        checks++;
        if (bus.matrix_out !== 64'd0) begin
            errors++;
            $display("FAIL update_before_tick: got %h expected 0", bus.matrix_out);
        end
        bus.vs = 1'b0;
        cycle();
        checks++;
        if (bus.upd_ack !== 1'b1 || bus.matrix_out !== 64'h0000_0000_0000_1021) begin
            errors++;
            $display("FAIL update_ack: ack=%b matrix=%h expected 1/0000000000001021",
                     bus.upd_ack, bus.matrix_out);
        end
        bus.vs = 1'b1;
        repeat (10) cycle();
        bus.upd_req = 1'b0;
        tick_frame(5);
        tick_frame(5);
        checks++;
        if (ack_count !== 1) begin
            errors++;
            $display("FAIL update_single_ack: got %0d acks expected 1", ack_count);
        end
    endtask

    task automatic test_game_over();
        bus.game_over = 1'b1;
        bus.upd_req   = 1'b1;
        bus.matrix_in = 64'hFFFF_0000_0000_0001;
        bus.vs        = 1'b0;
        cycle();
        checks++;
        if (bus.matrix_out !== 64'hFFFF_0000_0000_0001 || bus.upd_ack !== 1'b1 ||
            bus.mode !== 4'd2 || bus.frame_cnt !== 6'd0) begin
            errors++;
            $display("FAIL game_over_entry: matrix=%h ack=%b mode=%0d cnt=%0d expected ffff000000000001/1/2/0",
                     bus.matrix_out, bus.upd_ack, bus.mode, bus.frame_cnt);
        end
        bus.vs        = 1'b1;
        bus.upd_req   = 1'b0;
        bus.game_over = 1'b0;
        cycle();
        for (int i = 1; i <= 64; i++) begin
            tick_frame(2);
            if (i == 31) begin
                checks++;
                if (bus.mode !== 4'd2) begin
                    errors++;
                    $display("FAIL blink_31: mode=%0d expected 2", bus.mode);
                end
            end
            if (i == 32) begin
                checks++;
                if (bus.mode !== 4'd1 || bus.frame_cnt !== 6'd32) begin
                    errors++;
                    $display("FAIL blink_32: mode=%0d cnt=%0d expected 1/32", bus.mode, bus.frame_cnt);
                end
            end
            if (i == 64) begin
                checks++;
                if (bus.mode !== 4'd2 || bus.frame_cnt !== 6'd0) begin
                    errors++;
                    $display("FAIL blink_64: mode=%0d cnt=%0d expected 2/0", bus.mode, bus.frame_cnt);
                end
            end
        end
    endtask

    task automatic test_over_exit();
        bus.upd_req   = 1'b1;
        bus.matrix_in = {$urandom, $urandom};
        bus.vs        = 1'b0;
        cycle();
        checks++;
        if (bus.upd_ack !== 1'b1 || bus.matrix_out !== 64'hFFFF_0000_0000_0001) begin
            errors++;
            $display("FAIL over_update_held: ack=%b matrix=%h expected 1/ffff000000000001",
                     bus.upd_ack, bus.matrix_out);
        end
        bus.vs      = 1'b1;
        bus.upd_req = 1'b0;
        cycle();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        cycle();
        bus.vs = 1'b0;
        cycle();
        checks++;
        if (bus.mode !== 4'd0 || bus.matrix_out !== 64'd0) begin
            errors++;
            $display("FAIL over_exit: mode=%0d matrix=%h expected 0/0", bus.mode, bus.matrix_out);
        end
        bus.vs = 1'b1;
        cycle();
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        tick_frame(2);
        bus.upd_req   = 1'b1;
        bus.matrix_in = {$urandom, $urandom} | 64'd1;
        tick_frame(2);
        bus.matrix_in = {$urandom, $urandom};
        repeat (3) cycle();
        bus.vs = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.mode !== 4'd0 || bus.matrix_out !== 64'd0 || bus.upd_ack !== 1'b0 ||
            bus.frame_cnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_async: mode=%0d matrix=%h ack=%b cnt=%0d expected all 0",
                     bus.mode, bus.matrix_out, bus.upd_ack, bus.frame_cnt);
        end
        bus.vs    = 1'b1;
        ack_count = 0;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (5) cycle();
        checks++;
        if (ack_count !== 0 || bus.mode !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_handshake: acks=%0d mode=%0d expected 0/0", ack_count, bus.mode);
        end
        bus.upd_req = 1'b0;
    endtask

    task automatic test_random();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int f = 0; f < 300; f++) begin
            int len;
            len = $urandom_range(2, 6);
            for (int c = 0; c < len; c++) begin
                bus.vs        = (c == 0) ? 1'b0 : 1'b1;
                bus.start     = ($urandom_range(0, 9) == 0);
                bus.game_over = ($urandom_range(0, 19) == 0);
                if (!bus.upd_req) begin
                    bus.upd_req   = ($urandom_range(0, 2) == 0);
                    bus.matrix_in = {$urandom, $urandom};
                end else if (bus.upd_ack) begin
                    bus.upd_req = 1'b0;
                end
                cycle();
            end
        end
        bus.start     = 1'b0;
        bus.game_over = 1'b0;
        bus.upd_req   = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.vs        = 1'b1;
        bus.start     = 1'b0;
        bus.game_over = 1'b0;
        bus.upd_req   = 1'b0;
        bus.matrix_in = '0;
        model_reset();

        test_reset();
        test_start();
        test_update();
        test_game_over();
        test_over_exit();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
